// File: rtl/signed_divider_seq.sv
// signed_divider_seq
//   Sequential 8-bit signed divider. Non-restoring, one quotient bit per cycle on
//   operand magnitudes, with sign correction applied at the end. Quotient truncates
//   toward zero; the remainder takes the sign of the dividend.
//
// Ports
//   CLK       in   clock, rising edge
//   RESET     in   synchronous active-high reset
//   bgn       in   start request, sampled only while idle
//   ibusa     in   [7:0] signed dividend
//   ibusb     in   [7:0] signed divisor
//   obus_q    out  [7:0] signed quotient (registered)
//   obus_r    out  [7:0] signed remainder (registered)
//   stop      out  one-cycle done pulse
//   busy      out  high whenever not idle
//   div_zero  out  divisor was zero
//   ovf       out  quotient overflow (-128 / -1)
module signed_divider_seq (
   input  logic       CLK,
   input  logic       RESET,
   input  logic       bgn,
   input  logic [7:0] ibusa,
   input  logic [7:0] ibusb,
   output logic [7:0] obus_q,
   output logic [7:0] obus_r,
   output logic       stop,
   output logic       busy,
   output logic       div_zero,
   output logic       ovf
);

   typedef enum logic [2:0] {
      StIdle, StLoad, StIter, StCorrect, StSign, StDone
   } state_e;

   state_e      state_q, state_d;
   logic [7:0]  a_q, a_d;         // latched dividend
   logic [7:0]  b_q, b_d;         // latched divisor
   logic [7:0]  bmag_q, bmag_d;   // |B|, 128 for -128
   logic [8:0]  p_q, p_d;         // signed partial remainder
   logic [7:0]  qr_q, qr_d;       // dividend magnitude shifting out, quotient shifting in
   logic [2:0]  cnt_q, cnt_d;
   logic        sq_q, sq_d;       // quotient sign
   logic        sr_q, sr_d;       // remainder sign
   logic [7:0]  res_q_q, res_q_d;
   logic [7:0]  res_r_q, res_r_d;
   logic        dz_q, dz_d;
   logic        ovf_q, ovf_d;

   logic [7:0]  a_mag, b_mag;
   logic [8:0]  p_shift, p_iter;

   always_comb begin
      state_d = state_q;
      a_d     = a_q;
      b_d     = b_q;
      bmag_d  = bmag_q;
      p_d     = p_q;
      qr_d    = qr_q;
      cnt_d   = cnt_q;
      sq_d    = sq_q;
      sr_d    = sr_q;
      res_q_d = res_q_q;
      res_r_d = res_r_q;
      dz_d    = dz_q;
      ovf_d   = ovf_q;

      a_mag   = a_q[7] ? (~a_q + 8'd1) : a_q;
      b_mag   = b_q[7] ? (~b_q + 8'd1) : b_q;
      // Shift {P,Q} left; the add/subtract choice depends on the pre-shift sign of P.
      p_shift = {p_q[7:0], qr_q[7]};
      p_iter  = p_q[8] ? (p_shift + {1'b0, bmag_q}) : (p_shift - {1'b0, bmag_q});

      unique case (state_q)
         StIdle: begin
            if (bgn) begin
               a_d     = ibusa;
               b_d     = ibusb;
               state_d = StLoad;
            end
         end
         StLoad: begin
            bmag_d = b_mag;
            sq_d   = a_q[7] ^ b_q[7];
            sr_d   = a_q[7];
            p_d    = 9'd0;
            qr_d   = a_mag;
            cnt_d  = 3'd0;
            if (b_q == 8'h00) begin
               res_q_d = 8'h00;
               res_r_d = a_q;
               dz_d    = 1'b1;
               ovf_d   = 1'b0;
               state_d = StDone;
            end else if (a_q == 8'h80 && b_q == 8'hFF) begin
               res_q_d = 8'h80;
               res_r_d = 8'h00;
               dz_d    = 1'b0;
               ovf_d   = 1'b1;
               state_d = StDone;
            end else begin
               state_d = StIter;
            end
         end
         StIter: begin
            p_d   = p_iter;
            qr_d  = {qr_q[6:0], ~p_iter[8]};
            cnt_d = cnt_q + 3'd1;
            if (cnt_q == 3'd7) begin
               state_d = StCorrect;
            end
         end
         StCorrect: begin
            // Final restore so the remainder magnitude lands in [0, |B|).
            if (p_q[8]) begin
               p_d = p_q + {1'b0, bmag_q};
            end
            state_d = StSign;
         end
         StSign: begin
            res_q_d = sq_q ? (~qr_q + 8'd1) : qr_q;
            res_r_d = sr_q ? (~p_q[7:0] + 8'd1) : p_q[7:0];
            dz_d    = 1'b0;
            ovf_d   = 1'b0;
            state_d = StDone;
         end
         StDone: begin
            state_d = StIdle;
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   always_ff @(posedge CLK) begin
      if (RESET) begin
         state_q <= StIdle;
         a_q     <= 8'h00;
         b_q     <= 8'h00;
         bmag_q  <= 8'h00;
         p_q     <= 9'd0;
         qr_q    <= 8'h00;
         cnt_q   <= 3'd0;
         sq_q    <= 1'b0;
         sr_q    <= 1'b0;
         res_q_q <= 8'h00;
         res_r_q <= 8'h00;
         dz_q    <= 1'b0;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         b_q     <= b_d;
         bmag_q  <= bmag_d;
         p_q     <= p_d;
         qr_q    <= qr_d;
         cnt_q   <= cnt_d;
         sq_q    <= sq_d;
         sr_q    <= sr_d;
         res_q_q <= res_q_d;
         res_r_q <= res_r_d;
         dz_q    <= dz_d;
         ovf_q   <= ovf_d;
      end
   end

   assign obus_q   = res_q_q;
   assign obus_r   = res_r_q;
   assign div_zero = dz_q;
   assign ovf      = ovf_q;
   assign stop     = (state_q == StDone);
   assign busy     = (state_q != StIdle);

endmodule

// File: tb/tb_signed_divider_seq.sv
// tb_signed_divider_seq
//   Self-checking bench for signed_divider_seq: directed vector table, hand-written
//   reset / held-bgn sequences, and a randomized sweep against an integer model.
module tb_signed_divider_seq;

   logic       clk;
   logic       rst;
   logic       bgn;
   logic [7:0] ibusa, ibusb;
   logic [7:0] oq, orr;
   logic       stop, busy, dz, ov;

   int errs   = 0;
   int checks = 0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   signed_divider_seq dut (
      .CLK      (clk),
      .RESET    (rst),
      .bgn      (bgn),
      .ibusa    (ibusa),
      .ibusb    (ibusb),
      .obus_q   (oq),
      .obus_r   (orr),
      .stop     (stop),
      .busy     (busy),
      .div_zero (dz),
      .ovf      (ov)
   );

   typedef struct {
      logic [7:0] a;
      logic [7:0] b;
      logic [7:0] q;
      logic [7:0] r;
      logic       dz;
      logic       ov;
      int         lat;
      string      name;
   } vec_t;

   vec_t tbl[14];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errs++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Truncating reference with exception rules, in plain integer arithmetic.
   task automatic model(input logic [7:0] a, input logic [7:0] b,
                        output logic [7:0] q, output logic [7:0] r,
                        output logic edz, output logic eov, output int lat);
      int ai, bi, qi, ri;
      ai = int'($signed(a));
      bi = int'($signed(b));
      edz = 1'b0;
      eov = 1'b0;
      if (bi == 0) begin
         q = 8'h00; r = a; edz = 1'b1; lat = 1;
      end else if (ai == -128 && bi == -1) begin
         q = 8'h80; r = 8'h00; eov = 1'b1; lat = 1;
      end else begin
         qi = ai / bi;
         ri = ai % bi;
         q = qi[7:0];
         r = ri[7:0];
         lat = 11;
      end
   endtask

   // One operation: start, wait (bounded) for stop, check result, latency, busy, stop fall.
   // With scramble set, operands and bgn are randomized while the unit is busy.
   task automatic do_op(input logic [7:0] a, input logic [7:0] b, input logic [7:0] eq,
                        input logic [7:0] er, input logic edz, input logic eov,
                        input int elat, input bit scramble, input string name);
      int k;
      bit seen;
      bit busy_ok;
      @(negedge clk);
      ibusa = a; ibusb = b; bgn = 1'b1;
      @(posedge clk);
      @(negedge clk);
      bgn = 1'b0;
      busy_ok = busy;
      if (scramble) begin
         ibusa = 8'($urandom); ibusb = 8'($urandom); bgn = 1'($urandom);
      end
      k = 0;
      seen = 1'b0;
      while (!seen && k < 20) begin
         @(posedge clk);
         k++;
         @(negedge clk);
         if (stop) begin
            seen = 1'b1;
         end else begin
            busy_ok = busy_ok & busy;
            if (scramble) begin
               ibusa = 8'($urandom); ibusb = 8'($urandom); bgn = 1'($urandom);
            end
         end
      end
      bgn = 1'b0;
      chk({name, " stop_latency"}, 32'(k), 32'(elat));
      chk({name, " result q,r,dz,ovf,busy"}, {oq, orr, dz, ov, busy}, {eq, er, edz, eov, 1'b1});
      chk({name, " busy_while_running"}, {31'd0, busy_ok}, 32'd1);
      @(posedge clk);
      @(negedge clk);
      chk({name, " after_done stop,busy,q,r,dz,ovf"}, {stop, busy, oq, orr, dz, ov},
          {1'b0, 1'b0, eq, er, edz, eov});
   endtask

   logic [7:0] mq, mr;
   logic       mdz, mov;
   int         mlat;
   logic [7:0] ra, rb;
   logic [7:0] edge_vals[6];
   int         k;
   bit         seen;

   initial begin
      rst = 1'b1; bgn = 1'b0; ibusa = 8'h00; ibusb = 8'h00;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("reset_state", {stop, busy, oq, orr, dz, ov}, 22'd0);
      rst = 1'b0;

      tbl[0]  = '{8'd100, 8'd7,   8'h0E, 8'h02, 1'b0, 1'b0, 11, "100/7"};
      tbl[1]  = '{8'h9C,  8'd7,   8'hF2, 8'hFE, 1'b0, 1'b0, 11, "-100/7"};
      tbl[2]  = '{8'd100, 8'hF9,  8'hF2, 8'h02, 1'b0, 1'b0, 11, "100/-7"};
      tbl[3]  = '{8'h9C,  8'hF9,  8'h0E, 8'hFE, 1'b0, 1'b0, 11, "-100/-7"};
      tbl[4]  = '{8'h7F,  8'h80,  8'h00, 8'h7F, 1'b0, 1'b0, 11, "127/-128"};
      tbl[5]  = '{8'h80,  8'h01,  8'h80, 8'h00, 1'b0, 1'b0, 11, "-128/1"};
      tbl[6]  = '{8'h80,  8'hFF,  8'h80, 8'h00, 1'b0, 1'b1, 1,  "-128/-1"};
      tbl[7]  = '{8'd5,   8'd0,   8'h00, 8'h05, 1'b1, 1'b0, 1,  "5/0"};
      tbl[8]  = '{8'd9,   8'd3,   8'h03, 8'h00, 1'b0, 1'b0, 11, "9/3 after div0"};
      tbl[9]  = '{8'h80,  8'h00,  8'h00, 8'h80, 1'b1, 1'b0, 1,  "-128/0"};
      tbl[10] = '{8'h80,  8'h80,  8'h01, 8'h00, 1'b0, 1'b0, 11, "-128/-128"};
      tbl[11] = '{8'h00,  8'd5,   8'h00, 8'h00, 1'b0, 1'b0, 11, "0/5"};
      tbl[12] = '{8'hFF,  8'd2,   8'h00, 8'hFF, 1'b0, 1'b0, 11, "-1/2"};
      tbl[13] = '{8'h7F,  8'h01,  8'h7F, 8'h00, 1'b0, 1'b0, 11, "127/1"};

      for (int i = 0; i < 14; i++) begin
         do_op(tbl[i].a, tbl[i].b, tbl[i].q, tbl[i].r, tbl[i].dz, tbl[i].ov, tbl[i].lat,
               1'b0, tbl[i].name);
      end

      // Reset at E5 of 100/7: outputs (currently 127/1 results) clear, no stop pulse.
      @(negedge clk);
      ibusa = 8'd100; ibusb = 8'd7; bgn = 1'b1;
      @(posedge clk);
      @(negedge clk);
      bgn = 1'b0;
      repeat (4) @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      chk("reset_mid_op outputs", {stop, busy, oq, orr, dz, ov}, 22'd0);
      seen = 1'b0;
      repeat (12) begin
         @(posedge clk);
         @(negedge clk);
         if (stop || busy) seen = 1'b1;
      end
      chk("reset_mid_op no_stop", {31'd0, seen}, 32'd0);
      do_op(8'd50, 8'd8, 8'd6, 8'd2, 1'b0, 1'b0, 11, 1'b0, "50/8 after reset");

      // bgn held high: second op latches on first idle cycle; operands changed after E0.
      @(negedge clk);
      ibusa = 8'd100; ibusb = 8'd7; bgn = 1'b1;
      @(posedge clk);
      @(negedge clk);
      ibusa = 8'd50; ibusb = 8'd8;
      k = 0; seen = 1'b0;
      while (!seen && k < 20) begin
         @(posedge clk); k++; @(negedge clk);
         if (stop) seen = 1'b1;
      end
      chk("held_bgn first latency", 32'(k), 32'd11);
      chk("held_bgn first result", {oq, orr}, {8'h0E, 8'h02});
      k = 0; seen = 1'b0;
      while (!seen && k < 20) begin
         @(posedge clk); k++; @(negedge clk);
         if (stop) seen = 1'b1;
      end
      bgn = 1'b0;
      chk("held_bgn restart interval", 32'(k), 32'd13);
      chk("held_bgn second result", {oq, orr}, {8'd6, 8'd2});
      @(posedge clk);
      @(negedge clk);

      // Randomized sweep, biased toward boundary operands.
      edge_vals[0] = 8'h00; edge_vals[1] = 8'h80; edge_vals[2] = 8'hFF;
      edge_vals[3] = 8'h7F; edge_vals[4] = 8'h01; edge_vals[5] = 8'h81;
      for (int i = 0; i < 2500; i++) begin
         ra = ($urandom_range(0, 7) == 0) ? edge_vals[$urandom_range(0, 5)] : 8'($urandom);
         rb = ($urandom_range(0, 7) == 0) ? edge_vals[$urandom_range(0, 5)] : 8'($urandom);
         model(ra, rb, mq, mr, mdz, mov, mlat);
         do_op(ra, rb, mq, mr, mdz, mov, mlat, 1'($urandom), "random");
      end

      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

endmodule
